ps2_cmd_scheduler: RTL and testbench
====================================

Name: ps2_cmd_scheduler

Overview:
- Shares the single PS/2 host transmitter (SEND_BYTE/BYTE_TO_SEND/BYTE_SENT) among NUM_REQ command requesters, e.g. the mouse init sequencer and a runtime sample-rate/resolution configurator.
- Round-robin arbitration grants one requester at a time. The block transmits that requester's byte, waits for the device acknowledge on the receiver interface, and returns a one-cycle DONE with a response code.
- Sits between the requesters and the transmitter/receiver pair. It observes the receiver and never consumes packet bytes outside an ACK window.

Parameters:
NUM_REQ, 2, number of requesters (2..4)
ACK_TIMEOUT, 50000, cycles allowed from BYTE_SENT to ACK byte (1 ms at 50 MHz)
TX_TIMEOUT, 100000, cycles allowed from SEND_BYTE to BYTE_SENT
MAX_RETRY, 2, resend attempts on NACK (used only with PS2_CMD_RETRY_EN)

Ports:
CLK  in  1  clock
RESET  in  1  reset
REQ  in  NUM_REQ  per-requester request, level
REQ_BYTE  in  8*NUM_REQ  command byte per requester; requester i occupies bits [8i+7:8i]
GRANT  out  NUM_REQ  one-hot, current owner
DONE  out  1  one-cycle completion pulse to the GRANT owner
RESP_CODE  out  2  valid with DONE: 00 ACK, 01 NACK, 10 timeout, 11 rx error/unexpected byte
BUSY  out  1  high whenever state is not IDLE
SEND_BYTE  out  1  one-cycle transmit strobe
BYTE_TO_SEND  out  8  latched command byte
BYTE_SENT  in  1  transmitter completion pulse
BYTE_READ  in  8  received byte
BYTE_READY  in  1  received-byte valid pulse
BYTE_ERROR_CODE  in  2  receiver error, nonzero means error; qualified by BYTE_READY

Behaviour:
- Reset (RESET is synchronous and active-high, clock is CLK):
  - state becomes IDLE; GRANT=0, DONE=0, RESP_CODE=00, BUSY=0, SEND_BYTE=0, BYTE_TO_SEND=8'h00.
  - RR pointer=0, counters=0.
- IDLE:
  - If any REQ bit is high, grant the first set bit at or after the RR pointer (wrapping).
  - Register GRANT, latch REQ_BYTE of the winner into BYTE_TO_SEND, go to SEND.
  - Zero-cycle decision: GRANT is visible 1 cycle after REQ is sampled.
- SEND: SEND_BYTE=1 for exactly one cycle, clear the timer, go to WAIT_SENT.
- WAIT_SENT:
  - On BYTE_SENT, clear the timer and go to WAIT_ACK.
  - When the timer reaches TX_TIMEOUT-1, go to RESP with code 10.
- WAIT_ACK, on BYTE_READY:
  - BYTE_ERROR_CODE!=0 gives code 11.
  - Otherwise BYTE_READ=FA gives 00; FE or FC gives 01; any other value gives 11.
  - Go to RESP.
- WAIT_ACK timeout: when the timer reaches ACK_TIMEOUT-1, code 10.
- BYTE_READY arriving in the same cycle as timer expiry: the byte wins.
- RESP:
  - DONE=1 and RESP_CODE valid for one cycle; GRANT is held during that cycle.
  - RR pointer becomes (owner+1) mod NUM_REQ.
  - Next cycle: GRANT=0, go to IDLE.
- Requester rules:
  - Hold REQ and REQ_BYTE until DONE.
  - Drop of REQ by the owner mid-transaction is ignored; the transaction completes.
  - A REQ still high after DONE is re-arbitrated with lowest priority.
- BYTE_READY/BYTE_SENT outside their wait states are ignored.
- RESET mid-transaction aborts immediately with no DONE; SEND_BYTE is never asserted twice for one grant except under retry.
- Timer: saturating counter wide enough for max(ACK_TIMEOUT, TX_TIMEOUT).

Optional Feature:
- Macro: PS2_CMD_RETRY_EN.
- Defined:
  - NACK (FE only) with retry count < MAX_RETRY: increment count and return to SEND with the same byte and GRANT held.
  - FC, or count exhausted: RESP with code 01.
  - Count clears at grant.
- Undefined: any NACK goes directly to RESP with code 01; no retry counter is synthesized.

Decomposition:
- Package ps2_cmd_pkg:
  - state encoding (IDLE, SEND, WAIT_SENT, WAIT_ACK, RESP);
  - RESP_CODE constants;
  - byte constants ACK=FA, RESEND=FE, ERROR=FC.
- Sub-module ps2_rr_arbiter: combinational round-robin pick from REQ and pointer, giving a one-hot winner plus valid. It is natural to reuse elsewhere.

Test Plan:
- Single request:
  - Stimulus: REQ=01, REQ_BYTE[7:0]=F4; BYTE_SENT 10 cycles after SEND_BYTE; BYTE_READY with BYTE_READ=FA.
  - Response: exactly one SEND_BYTE with BYTE_TO_SEND=F4; DONE with RESP_CODE=00; GRANT returns to 0.
- Contention:
  - Stimulus: REQ=11 held; bytes F3 (requester 0) and C8 (requester 1); each ACKed with FA.
  - Response: grants alternate 01, 10, 01; BYTE_TO_SEND follows the owner.
- Timeouts:
  - ACK case: no BYTE_READY after BYTE_SENT gives DONE with code 10 exactly ACK_TIMEOUT cycles after BYTE_SENT.
  - TX case: no BYTE_SENT gives code 10 after TX_TIMEOUT.
- Rx error and unexpected byte:
  - BYTE_READY with BYTE_ERROR_CODE=01 gives code 11.
  - BYTE_READ=AA gives code 11.
- NACK:
  - Stimulus: BYTE_READ=FE three times.
  - With PS2_CMD_RETRY_EN: 3 SEND_BYTE pulses, then code 01.
  - Without PS2_CMD_RETRY_EN: 1 pulse, then code 01.
- Reset mid-operation: assert RESET in WAIT_ACK -> next cycle all outputs at reset values, no DONE, RR pointer=0.

Source files
------------

// File: rtl/ps2_cmd_pkg.sv
// ---------------------------------------------------------------------------
// ps2_cmd_pkg
//   Shared definitions for the PS/2 command scheduler:
//     - ps2_cmd_state_e : scheduler FSM state encoding
//     - RESP_*          : response codes reported with DONE
//     - BYTE_*          : device reply bytes (ACK / RESEND / ERROR)
//     - classify_ack()  : maps a received byte + receiver error to a code
// ---------------------------------------------------------------------------
package ps2_cmd_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_SEND      = 3'd1,
    ST_WAIT_SENT = 3'd2,
    ST_WAIT_ACK  = 3'd3,
    ST_RESP      = 3'd4
  } ps2_cmd_state_e;

  localparam logic [1:0] RESP_ACK     = 2'b00;
  localparam logic [1:0] RESP_NACK    = 2'b01;
  localparam logic [1:0] RESP_TIMEOUT = 2'b10;
  localparam logic [1:0] RESP_RXERR   = 2'b11;

  localparam logic [7:0] BYTE_ACK    = 8'hFA;
  localparam logic [7:0] BYTE_RESEND = 8'hFE;
  localparam logic [7:0] BYTE_ERROR  = 8'hFC;

  // A receiver error always dominates the byte value, because the byte
  // cannot be trusted when the frame was bad.
  function automatic logic [1:0] classify_ack(input logic [7:0] rx_byte,
                                              input logic [1:0] rx_err);
    logic [1:0] code;
    if (rx_err != 2'b00) begin
      code = RESP_RXERR;
    end else if (rx_byte == BYTE_ACK) begin
      code = RESP_ACK;
    end else if ((rx_byte == BYTE_RESEND) || (rx_byte == BYTE_ERROR)) begin
      code = RESP_NACK;
    end else begin
      code = RESP_RXERR;
    end
    return code;
  endfunction

endpackage

// File: rtl/ps2_rr_arbiter.sv
// ---------------------------------------------------------------------------
// ps2_rr_arbiter
//   Purely combinational round-robin pick. Searches req starting at ptr and
//   wrapping around, returns a one-hot winner and a valid flag.
//
//   Parameters:
//     NUM_REQ : number of requesters
//     PTR_W   : width of the pointer (clog2(NUM_REQ))
//   Ports:
//     req   in  NUM_REQ  request vector
//     ptr   in  PTR_W    index with highest priority this round
//     grant out NUM_REQ  one-hot winner (all zero when no request)
//     valid out 1        at least one request present
// ---------------------------------------------------------------------------
module ps2_rr_arbiter #(
  parameter int NUM_REQ = 2,
  parameter int PTR_W   = 1
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [PTR_W-1:0]   ptr,
  output logic [NUM_REQ-1:0] grant,
  output logic               valid
);

  // Two passes instead of a rotate: the first pass only considers indices
  // at or above ptr; if nothing was found there, the second pass takes the
  // lowest set index, which must lie below ptr (the wrapped part).
  always_comb begin
    grant = '0;
    valid = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!valid && req[i] && (i >= int'(ptr))) begin
        grant[i] = 1'b1;
        valid    = 1'b1;
      end
    end
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!valid && req[i]) begin
        grant[i] = 1'b1;
        valid    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/ps2_cmd_scheduler.sv
// ---------------------------------------------------------------------------
// ps2_cmd_scheduler
//   Shares one PS/2 host transmitter among NUM_REQ command requesters.
//   A round-robin arbiter picks one requester, its byte is sent, the device
//   acknowledge is awaited on the receiver side and a one-cycle DONE with a
//   response code is returned to the owner.
//
//   Optional build macro: PS2_CMD_RETRY_EN
//     defined   : an FE reply re-sends the same byte up to MAX_RETRY times
//     undefined : any NACK (FE/FC) completes immediately with code 01
//
//   Ports:
//     CLK, RESET              clock, synchronous active-high reset
//     REQ[NUM_REQ]            level requests
//     REQ_BYTE[8*NUM_REQ]     command byte per requester (i at [8i+7:8i])
//     GRANT[NUM_REQ]          one-hot current owner
//     DONE                    one-cycle completion pulse
//     RESP_CODE[2]            00 ACK, 01 NACK, 10 timeout, 11 rx error
//     BUSY                    state is not IDLE
//     SEND_BYTE/BYTE_TO_SEND  transmit strobe and byte
//     BYTE_SENT               transmitter done pulse
//     BYTE_READ/BYTE_READY/BYTE_ERROR_CODE  receiver side (observe only)
// ---------------------------------------------------------------------------
module ps2_cmd_scheduler
  import ps2_cmd_pkg::*;
#(
  parameter int NUM_REQ     = 2,
  parameter int ACK_TIMEOUT = 50000,
  parameter int TX_TIMEOUT  = 100000,
  parameter int MAX_RETRY   = 2
) (
  input  logic                   CLK,
  input  logic                   RESET,
  input  logic [NUM_REQ-1:0]     REQ,
  input  logic [8*NUM_REQ-1:0]   REQ_BYTE,
  output logic [NUM_REQ-1:0]     GRANT,
  output logic                   DONE,
  output logic [1:0]             RESP_CODE,
  output logic                   BUSY,
  output logic                   SEND_BYTE,
  output logic [7:0]             BYTE_TO_SEND,
  input  logic                   BYTE_SENT,
  input  logic [7:0]             BYTE_READ,
  input  logic                   BYTE_READY,
  input  logic [1:0]             BYTE_ERROR_CODE
);

  localparam int PTR_W     = $clog2(NUM_REQ);
  localparam int TIMER_MAX = (ACK_TIMEOUT > TX_TIMEOUT) ? ACK_TIMEOUT : TX_TIMEOUT;
  localparam int TIMER_W   = $clog2(TIMER_MAX + 1);
  localparam logic [TIMER_W-1:0] ACK_LAST = TIMER_W'(ACK_TIMEOUT - 1);
  localparam logic [TIMER_W-1:0] TX_LAST  = TIMER_W'(TX_TIMEOUT - 1);

  // Elaboration-time guard on the supported configuration range.
  if ((NUM_REQ < 2) || (NUM_REQ > 4) || (MAX_RETRY < 0) ||
      (ACK_TIMEOUT < 1) || (TX_TIMEOUT < 1)) begin : g_param_check
    $error("ps2_cmd_scheduler: parameter out of supported range");
  end

  ps2_cmd_state_e       state_q, state_d;
  logic [TIMER_W-1:0]   timer_q, timer_d, timer_inc;
  logic [NUM_REQ-1:0]   grant_q, grant_d;
  logic [7:0]           byte_q, byte_d;
  logic [1:0]           code_q, code_d;
  logic [PTR_W-1:0]     ptr_q, ptr_d, ptr_after;

  logic [NUM_REQ-1:0]   arb_grant;
  logic                 arb_valid;
  logic [7:0]           winner_byte;
  logic [1:0]           ack_code;

`ifdef PS2_CMD_RETRY_EN
  localparam int RETRY_W = (MAX_RETRY < 1) ? 1 : $clog2(MAX_RETRY + 1);
  logic [RETRY_W-1:0]   retry_q, retry_d;
  logic                 retry_ok;

  // Only an explicit RESEND is worth repeating; FC means the device
  // rejected the command itself.
  assign retry_ok = (BYTE_READ == BYTE_RESEND) && (retry_q < RETRY_W'(MAX_RETRY));
`endif

  ps2_rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .PTR_W   (PTR_W)
  ) u_arb (
    .req   (REQ),
    .ptr   (ptr_q),
    .grant (arb_grant),
    .valid (arb_valid)
  );

  assign ack_code  = classify_ack(BYTE_READ, BYTE_ERROR_CODE);
  assign timer_inc = (timer_q == '1) ? timer_q : timer_q + 1'b1;

  // Mux the winning requester's byte out of the packed REQ_BYTE bus.
  always_comb begin
    winner_byte = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (arb_grant[i]) begin
        winner_byte = REQ_BYTE[8*i +: 8];
      end
    end
  end

  // Pointer for the next round: one past the current owner, wrapping, so a
  // requester that keeps REQ high drops to lowest priority.
  always_comb begin
    ptr_after = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant_q[i]) begin
        ptr_after = (i == NUM_REQ - 1) ? '0 : PTR_W'(i + 1);
      end
    end
  end

  // State and datapath registers.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q <= ST_IDLE;
      timer_q <= '0;
      grant_q <= '0;
      byte_q  <= 8'h00;
      code_q  <= RESP_ACK;
      ptr_q   <= '0;
`ifdef PS2_CMD_RETRY_EN
      retry_q <= '0;
`endif
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      grant_q <= grant_d;
      byte_q  <= byte_d;
      code_q  <= code_d;
      ptr_q   <= ptr_d;
`ifdef PS2_CMD_RETRY_EN
      retry_q <= retry_d;
`endif
    end
  end

  // Next-state logic. In both wait states the incoming pulse is checked
  // before the timer, so an event landing on the last allowed cycle wins.
  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    grant_d = grant_q;
    byte_d  = byte_q;
    code_d  = code_q;
    ptr_d   = ptr_q;
`ifdef PS2_CMD_RETRY_EN
    retry_d = retry_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (arb_valid) begin
          grant_d = arb_grant;
          byte_d  = winner_byte;
          state_d = ST_SEND;
`ifdef PS2_CMD_RETRY_EN
          retry_d = '0;
`endif
        end
      end
      ST_SEND: begin
        timer_d = '0;
        state_d = ST_WAIT_SENT;
      end
      ST_WAIT_SENT: begin
        if (BYTE_SENT) begin
          timer_d = '0;
          state_d = ST_WAIT_ACK;
        end else if (timer_q == TX_LAST) begin
          code_d  = RESP_TIMEOUT;
          state_d = ST_RESP;
        end else begin
          timer_d = timer_inc;
        end
      end
      ST_WAIT_ACK: begin
        if (BYTE_READY) begin
          code_d  = ack_code;
          state_d = ST_RESP;
`ifdef PS2_CMD_RETRY_EN
          if ((ack_code == RESP_NACK) && retry_ok) begin
            code_d  = code_q;
            retry_d = retry_q + 1'b1;
            state_d = ST_SEND;
          end
`endif
        end else if (timer_q == ACK_LAST) begin
          code_d  = RESP_TIMEOUT;
          state_d = ST_RESP;
        end else begin
          timer_d = timer_inc;
        end
      end
      ST_RESP: begin
        grant_d = '0;
        ptr_d   = ptr_after;
        state_d = ST_IDLE;
      end
      default: begin
        grant_d = '0;
        state_d = ST_IDLE;
      end
    endcase
  end

  assign GRANT        = grant_q;
  assign DONE         = (state_q == ST_RESP);
  assign RESP_CODE    = (state_q == ST_RESP) ? code_q : RESP_ACK;
  assign BUSY         = (state_q != ST_IDLE);
  assign SEND_BYTE    = (state_q == ST_SEND);
  assign BYTE_TO_SEND = byte_q;

endmodule

// File: tb/tb_ps2_cmd_scheduler.sv
// ---------------------------------------------------------------------------
// tb_ps2_cmd_scheduler
//   Directed bench for ps2_cmd_scheduler with short timeouts. Inputs are
//   driven and outputs sampled 1 time unit after the rising edge.
// ---------------------------------------------------------------------------
module tb_ps2_cmd_scheduler;

  localparam int NREQ   = 2;
  localparam int ACK_TO = 20;
  localparam int TX_TO  = 30;
  localparam int MAXR   = 2;

  logic              CLK;
  logic              RESET;
  logic [NREQ-1:0]   REQ;
  logic [8*NREQ-1:0] REQ_BYTE;
  logic [NREQ-1:0]   GRANT;
  logic              DONE;
  logic [1:0]        RESP_CODE;
  logic              BUSY;
  logic              SEND_BYTE;
  logic [7:0]        BYTE_TO_SEND;
  logic              BYTE_SENT;
  logic [7:0]        BYTE_READ;
  logic              BYTE_READY;
  logic [1:0]        BYTE_ERROR_CODE;

  int checks = 0;
  int passes = 0;

  ps2_cmd_scheduler #(
    .NUM_REQ     (NREQ),
    .ACK_TIMEOUT (ACK_TO),
    .TX_TIMEOUT  (TX_TO),
    .MAX_RETRY   (MAXR)
  ) dut (
    .CLK             (CLK),
    .RESET           (RESET),
    .REQ             (REQ),
    .REQ_BYTE        (REQ_BYTE),
    .GRANT           (GRANT),
    .DONE            (DONE),
    .RESP_CODE       (RESP_CODE),
    .BUSY            (BUSY),
    .SEND_BYTE       (SEND_BYTE),
    .BYTE_TO_SEND    (BYTE_TO_SEND),
    .BYTE_SENT       (BYTE_SENT),
    .BYTE_READ       (BYTE_READ),
    .BYTE_READY      (BYTE_READY),
    .BYTE_ERROR_CODE (BYTE_ERROR_CODE)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic do_reset();
    RESET = 1'b1;
    REQ = '0;
    REQ_BYTE = '0;
    BYTE_SENT = 1'b0;
    BYTE_READ = 8'h00;
    BYTE_READY = 1'b0;
    BYTE_ERROR_CODE = 2'b00;
    step();
    step();
    RESET = 1'b0;
  endtask

  // Behaves as transmitter + device: every SEND_BYTE is followed by
  // BYTE_SENT after sent_delay cycles (0 = never), every BYTE_SENT by
  // BYTE_READY after rx_delay cycles (0 = never). Returns at DONE or after
  // a bounded number of cycles with got_done=0.
  task automatic run_device(input int sent_delay, input int rx_delay,
                            input logic [7:0] rx_byte, input logic [1:0] rx_err,
                            output bit got_done, output logic [1:0] code,
                            output logic [1:0] grant_at_done, output int sends,
                            output int sent_to_done, output int send_to_done);
    int tx_wait, rx_wait, sent_iter, send_iter;
    tx_wait = 0; rx_wait = 0; sent_iter = 0; send_iter = 0;
    got_done = 1'b0; code = 2'bxx; grant_at_done = '0; sends = 0;
    sent_to_done = -1; send_to_done = -1;
    for (int it = 0; it < 300; it++) begin
      BYTE_SENT = 1'b0;
      BYTE_READY = 1'b0;
      if (DONE === 1'b1) begin
        got_done = 1'b1;
        code = RESP_CODE;
        grant_at_done = GRANT;
        sent_to_done = it - sent_iter;
        send_to_done = it - send_iter;
        break;
      end
      if (rx_wait > 0) begin
        rx_wait--;
        if (rx_wait == 0) begin
          BYTE_READY = 1'b1;
          BYTE_READ = rx_byte;
          BYTE_ERROR_CODE = rx_err;
        end
      end
      if (SEND_BYTE === 1'b1) begin
        sends++;
        send_iter = it;
        tx_wait = sent_delay;
      end else if (tx_wait > 0) begin
        tx_wait--;
        if (tx_wait == 0) begin
          BYTE_SENT = 1'b1;
          sent_iter = it;
          rx_wait = rx_delay;
        end
      end
      step();
    end
    BYTE_SENT = 1'b0;
    BYTE_READY = 1'b0;
    BYTE_ERROR_CODE = 2'b00;
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (GRANT !== 2'b00) $display("[TB] FAIL reset_grant: got %b expected 00", GRANT); else passes++;
    checks++; if (DONE !== 1'b0) $display("[TB] FAIL reset_done: got %b expected 0", DONE); else passes++;
    checks++; if (RESP_CODE !== 2'b00) $display("[TB] FAIL reset_code: got %b expected 00", RESP_CODE); else passes++;
    checks++; if (BUSY !== 1'b0) $display("[TB] FAIL reset_busy: got %b expected 0", BUSY); else passes++;
    checks++; if (SEND_BYTE !== 1'b0) $display("[TB] FAIL reset_send: got %b expected 0", SEND_BYTE); else passes++;
    checks++; if (BYTE_TO_SEND !== 8'h00) $display("[TB] FAIL reset_byte: got %h expected 00", BYTE_TO_SEND); else passes++;
  endtask

  task automatic test_ignored_pulses();
    do_reset();
    BYTE_SENT = 1'b1; BYTE_READY = 1'b1; BYTE_READ = 8'hFA;
    step();
    BYTE_SENT = 1'b0; BYTE_READY = 1'b0;
    step();
    checks++; if (BUSY !== 1'b0) $display("[TB] FAIL idle_pulse_busy: got %b expected 0", BUSY); else passes++;
    checks++; if (DONE !== 1'b0) $display("[TB] FAIL idle_pulse_done: got %b expected 0", DONE); else passes++;
  endtask

  task automatic test_single();
    bit gd; logic [1:0] c, g; int s, a, b;
    do_reset();
    REQ = 2'b01; REQ_BYTE = 16'h00F4;
    step();
    checks++; if (GRANT !== 2'b01) $display("[TB] FAIL single_grant: got %b expected 01", GRANT); else passes++;
    checks++; if (SEND_BYTE !== 1'b1) $display("[TB] FAIL single_send: got %b expected 1", SEND_BYTE); else passes++;
    checks++; if (BYTE_TO_SEND !== 8'hF4) $display("[TB] FAIL single_byte: got %h expected F4", BYTE_TO_SEND); else passes++;
    run_device(10, 2, 8'hFA, 2'b00, gd, c, g, s, a, b);
    REQ = 2'b00;
    checks++; if (gd !== 1'b1) $display("[TB] FAIL single_done: got %b expected 1", gd); else passes++;
    checks++; if (c !== 2'b00) $display("[TB] FAIL single_code: got %b expected 00", c); else passes++;
    checks++; if (g !== 2'b01) $display("[TB] FAIL single_grant_at_done: got %b expected 01", g); else passes++;
    checks++; if (s != 1) $display("[TB] FAIL single_send_count: got %0d expected 1", s); else passes++;
    step();
    checks++; if (GRANT !== 2'b00) $display("[TB] FAIL single_grant_release: got %b expected 00", GRANT); else passes++;
    checks++; if (DONE !== 1'b0) $display("[TB] FAIL single_done_width: got %b expected 0", DONE); else passes++;
    checks++; if (BUSY !== 1'b0) $display("[TB] FAIL single_busy_after: got %b expected 0", BUSY); else passes++;
  endtask

  task automatic test_contention();
    bit gd; logic [1:0] c, g; int s, a, b;
    logic [1:0] exp_g [3];
    logic [7:0] exp_b [3];
    exp_g[0] = 2'b01; exp_g[1] = 2'b10; exp_g[2] = 2'b01;
    exp_b[0] = 8'hF3; exp_b[1] = 8'hC8; exp_b[2] = 8'hF3;
    do_reset();
    REQ = 2'b11; REQ_BYTE = {8'hC8, 8'hF3};
    for (int r = 0; r < 3; r++) begin
      if (r > 0) begin
        step();
        checks++; if (GRANT !== 2'b00) $display("[TB] FAIL contention_gap%0d: got %b expected 00", r, GRANT); else passes++;
      end
      step();
      checks++; if (GRANT !== exp_g[r]) $display("[TB] FAIL contention_grant%0d: got %b expected %b", r, GRANT, exp_g[r]); else passes++;
      checks++; if (BYTE_TO_SEND !== exp_b[r]) $display("[TB] FAIL contention_byte%0d: got %h expected %h", r, BYTE_TO_SEND, exp_b[r]); else passes++;
      run_device(4, 2, 8'hFA, 2'b00, gd, c, g, s, a, b);
      checks++; if (gd !== 1'b1) $display("[TB] FAIL contention_done%0d: got %b expected 1", r, gd); else passes++;
      checks++; if (c !== 2'b00) $display("[TB] FAIL contention_code%0d: got %b expected 00", r, c); else passes++;
    end
    REQ = 2'b00;
    step();
  endtask

  task automatic test_timeouts();
    bit gd; logic [1:0] c, g; int s, a, b;
    // ACK timeout, owner drops REQ right after the grant.
    do_reset();
    REQ = 2'b01; REQ_BYTE = 16'h00F2;
    step();
    REQ = 2'b00;
    run_device(5, 0, 8'h00, 2'b00, gd, c, g, s, a, b);
    checks++; if (gd !== 1'b1) $display("[TB] FAIL ack_to_done: got %b expected 1", gd); else passes++;
    checks++; if (c !== 2'b10) $display("[TB] FAIL ack_to_code: got %b expected 10", c); else passes++;
    // BYTE_SENT is captured at the edge closing its cycle; DONE must rise
    // ACK_TO edges after that one.
    checks++; if (a - 1 != ACK_TO) $display("[TB] FAIL ack_to_latency: got %0d expected %0d", a - 1, ACK_TO); else passes++;
    // Reply landing on the last allowed cycle beats the timeout.
    do_reset();
    REQ = 2'b01; REQ_BYTE = 16'h00F2;
    step();
    run_device(5, ACK_TO, 8'hFA, 2'b00, gd, c, g, s, a, b);
    checks++; if (c !== 2'b00) $display("[TB] FAIL ack_edge_code: got %b expected 00", c); else passes++;
    // TX timeout: SEND cycle itself plus TX_TO waiting cycles.
    do_reset();
    REQ = 2'b01; REQ_BYTE = 16'h00F2;
    step();
    run_device(0, 0, 8'h00, 2'b00, gd, c, g, s, a, b);
    checks++; if (c !== 2'b10) $display("[TB] FAIL tx_to_code: got %b expected 10", c); else passes++;
    checks++; if (b != TX_TO + 1) $display("[TB] FAIL tx_to_latency: got %0d expected %0d", b, TX_TO + 1); else passes++;
    checks++; if (s != 1) $display("[TB] FAIL tx_to_sends: got %0d expected 1", s); else passes++;
    // BYTE_SENT on the last allowed cycle is accepted.
    do_reset();
    REQ = 2'b01; REQ_BYTE = 16'h00F2;
    step();
    run_device(TX_TO, 2, 8'hFA, 2'b00, gd, c, g, s, a, b);
    checks++; if (c !== 2'b00) $display("[TB] FAIL tx_edge_code: got %b expected 00", c); else passes++;
  endtask

  task automatic test_rx_errors();
    bit gd; logic [1:0] c, g; int s, a, b;
    do_reset();
    REQ = 2'b10; REQ_BYTE = 16'hE800;
    step();
    checks++; if (GRANT !== 2'b10) $display("[TB] FAIL rxerr_grant: got %b expected 10", GRANT); else passes++;
    run_device(3, 2, 8'hFA, 2'b01, gd, c, g, s, a, b);
    checks++; if (c !== 2'b11) $display("[TB] FAIL rxerr_code: got %b expected 11", c); else passes++;
    do_reset();
    REQ = 2'b01; REQ_BYTE = 16'h00E8;
    step();
    run_device(3, 2, 8'hAA, 2'b00, gd, c, g, s, a, b);
    checks++; if (c !== 2'b11) $display("[TB] FAIL unexpected_code: got %b expected 11", c); else passes++;
  endtask

  task automatic test_nack();
    bit gd; logic [1:0] c, g; int s, a, b, exp_s;
`ifdef PS2_CMD_RETRY_EN
    exp_s = MAXR + 1;
`else
    exp_s = 1;
`endif
    do_reset();
    REQ = 2'b01; REQ_BYTE = 16'h00F3;
    step();
    run_device(3, 2, 8'hFE, 2'b00, gd, c, g, s, a, b);
    checks++; if (c !== 2'b01) $display("[TB] FAIL nack_fe_code: got %b expected 01", c); else passes++;
    checks++; if (s != exp_s) $display("[TB] FAIL nack_fe_sends: got %0d expected %0d", s, exp_s); else passes++;
    do_reset();
    REQ = 2'b01; REQ_BYTE = 16'h00F3;
    step();
    run_device(3, 2, 8'hFC, 2'b00, gd, c, g, s, a, b);
    checks++; if (c !== 2'b01) $display("[TB] FAIL nack_fc_code: got %b expected 01", c); else passes++;
    checks++; if (s != 1) $display("[TB] FAIL nack_fc_sends: got %0d expected 1", s); else passes++;
  endtask

  task automatic test_reset_mid();
    bit gd; logic [1:0] c, g; int s, a, b;
    do_reset();
    // Complete one round for requester 0 so the pointer moves to 1.
    REQ = 2'b01; REQ_BYTE = 16'h5511;
    step();
    run_device(3, 2, 8'hFA, 2'b00, gd, c, g, s, a, b);
    REQ = 2'b10;
    step();
    step();
    checks++; if (GRANT !== 2'b10) $display("[TB] FAIL mid_grant: got %b expected 10", GRANT); else passes++;
    step();
    BYTE_SENT = 1'b1;
    step();
    BYTE_SENT = 1'b0;
    checks++; if (BUSY !== 1'b1) $display("[TB] FAIL mid_busy: got %b expected 1", BUSY); else passes++;
    RESET = 1'b1;
    step();
    checks++; if (GRANT !== 2'b00) $display("[TB] FAIL mid_reset_grant: got %b expected 00", GRANT); else passes++;
    checks++; if (DONE !== 1'b0) $display("[TB] FAIL mid_reset_done: got %b expected 0", DONE); else passes++;
    checks++; if (BUSY !== 1'b0) $display("[TB] FAIL mid_reset_busy: got %b expected 0", BUSY); else passes++;
    checks++; if (BYTE_TO_SEND !== 8'h00) $display("[TB] FAIL mid_reset_byte: got %h expected 00", BYTE_TO_SEND); else passes++;
    checks++; if (SEND_BYTE !== 1'b0) $display("[TB] FAIL mid_reset_send: got %b expected 0", SEND_BYTE); else passes++;
    RESET = 1'b0;
    REQ = 2'b11;
    step();
    // Pointer back at 0, so requester 0 wins despite requester 1 asking.
    checks++; if (GRANT !== 2'b01) $display("[TB] FAIL mid_ptr_cleared: got %b expected 01", GRANT); else passes++;
    REQ = 2'b00;
  endtask

  initial begin
    test_reset();
    test_ignored_pulses();
    test_single();
    test_contention();
    test_timeouts();
    test_rx_errors();
    test_nack();
    test_reset_mid();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
